i2s_rcvr_ctrl: RTL and testbench
================================

# i2s_rcvr_ctrl

Control and framing stage of the I2S receiver. It sits directly upstream of the I2S receiver shift register. It synchronizes the external I2S lines (SCK, WS, SD) into `clk`, decodes frame boundaries, and drives the shift register's `shift`/`data_in` one bit per SCK rising edge. It also captures the register's 32-bit parallel word per channel and presents left/right sample pairs on a valid/ready handshake.

## Interface
- `WORD_BITS`, 24, bits captured per channel (1..32); extra SCK bits in a channel are ignored
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers (≥2)

- `clk` in 1: system clock; must be ≥4× SCK frequency
- `n_rst` in 1: reset, **synchronous, active-high** (port name kept per codebase)
- `i2s_sck` in 1: async bit clock
- `i2s_ws` in 1: async word select (0 = left, 1 = right)
- `i2s_sd` in 1: async serial data, MSB first
- `shift` out 1: one-`clk` shift enable to the shift register
- `data_in` out 1: serial bit to the shift register, valid while `shift`=1
- `sr_data` in 32: parallel output of the shift register (bit 0 = newest)
- `left_out` out 32: left sample, `sr_data[WORD_BITS-1:0]` zero-extended
- `right_out` out 32: right sample, same format
- `sample_valid` out 1: pair available
- `sample_ready` in 1: consumer accepts the pair
- `overrun` out 1: sticky; a completed pair was dropped
- `clear_overrun` in 1: clears `overrun`
- `frame_err` out 1: one-cycle pulse; a channel ended before `WORD_BITS` bits

## Operation
- Sync: SCK, WS and SD each pass through `SYNC_STAGES` flip-flops. `sck_rise` = synced SCK is 1 and its previous value was 0.
- On each `sck_rise`, sample synced WS and SD. `ws_chg` = sampled WS differs from the previous sampled WS.
- FSM states: IDLE, DELAY, SHIFT, WAIT.
  - IDLE: no shifting. On `ws_chg`, go to DELAY.
  - DELAY: the next `sck_rise` is skipped (I2S one-bit delay). Then go to SHIFT with `bit_cnt`=0.
  - SHIFT: on each `sck_rise`, pulse `shift` with `data_in`=SD and increment `bit_cnt`. When `bit_cnt` reaches `WORD_BITS`, raise the capture strobe and go to WAIT.
  - WAIT: ignore bits. On `ws_chg`, go to DELAY.
  - `ws_chg` while in SHIFT (short word): pulse `frame_err`, discard the partial word, go to DELAY.
- Capture loads `sr_data[WORD_BITS-1:0]` into the left or right holding register, selected by the WS value of the word being captured.
- Pairing:
  - A captured left word sets `left_have`.
  - A captured right word with `left_have`=1 completes a pair and clears `left_have`.
  - A right word without `left_have` is discarded.
  - A `frame_err` clears `left_have`.
- Completed pair with `sample_valid`=0: load `left_out`/`right_out` and set `sample_valid`.
- Completed pair with `sample_valid`=1 and the pair not being accepted this cycle: drop the new pair, hold the outputs, set `overrun`.
- Handshake: `sample_valid & sample_ready` at a `clk` edge consumes the pair. If a new pair completes in that same cycle, it loads and `sample_valid` stays 1.
- `overrun` clears on `clear_overrun`. If a new overrun occurs in the same cycle as `clear_overrun`, set wins.
- Reset mid-operation: partial word and `left_have` are discarded; the FSM restarts in IDLE and needs a fresh WS edge.

## Timing
- Reset values: `shift`=0, `data_in`=0, `left_out`=0, `right_out`=0, `sample_valid`=0, `overrun`=0, `frame_err`=0, FSM=IDLE, `bit_cnt`=0, `left_have`=0.
- `sck_rise` is detected in cycle N, where N is `SYNC_STAGES`+1 clks after the pin edge. `shift` and `data_in` are registered and high in cycle N+1 for exactly one cycle.
- Capture strobe is in cycle N+2 after the final shift, so `sr_data` is already updated. The holding register loads at the end of N+2.
- `sample_valid` rises at the end of cycle N+3 after the right word's final shift.
- At most one `shift` pulse per SCK period.

## Configuration
- `I2S_RCVR_LEFT_JUSTIFIED_EN`:
  - Undefined: standard I2S; DELAY state skips one SCK after a WS change.
  - Defined: left-justified format; `ws_chg` transitions directly to SHIFT, and the bit sampled on that same `sck_rise` is shifted as the MSB.

## Test plan
- WORD_BITS=24, SCK=clk/8, 32 SCK per channel, left=0xA5A5A5, right=0x3C3C3C → `left_out`=0x00A5A5A5, `right_out`=0x003C3C3C, `sample_valid`=1, exactly 24 `shift` pulses per channel.
- `sample_ready` held high for 4 frames → `sample_valid` high exactly one cycle per frame, no `overrun`.
- `sample_ready` low across 2 frames → first pair held unchanged, `overrun`=1; pulse `clear_overrun` → `overrun`=0.
- WS toggles after 10 left bits → one `frame_err` pulse, no `sample_valid` for that frame, next full frame delivered correctly.
- Assert `n_rst` mid-left-word → all outputs 0 next cycle; no `shift` until the next WS edge; following frame correct.
- Macro defined, left-justified stimulus left=0x800001 → `left_out`=0x00800001.

Source files
------------

// File: rtl/i2s_rcvr_ctrl.sv
// I2S receiver control/framing: synchronizes SCK/WS/SD, drives the shift register and
// delivers left/right sample pairs on a valid/ready handshake. Optional: I2S_RCVR_LEFT_JUSTIFIED_EN.
module i2s_rcvr_ctrl #(
    parameter int WORD_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i2s_sck,
    input  logic        i2s_ws,
    input  logic        i2s_sd,
    output logic        shift,
    output logic        data_in,
    input  logic [31:0] sr_data,
    output logic [31:0] left_out,
    output logic [31:0] right_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    input  logic        clear_overrun,
    output logic        frame_err
);

    localparam logic [5:0]  WORD_LAST = 6'(WORD_BITS - 1);
    localparam logic [31:0] WORD_MASK = (WORD_BITS >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'h1 << WORD_BITS) - 32'h1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r, ws_sync_r, sd_sync_r;
    logic        sck_prev_r, ws_smp_r, ws_valid_r;
    logic        sck_s, ws_s, sd_s, sck_rise_s, ws_chg_s;
    state_t      state_r, state_nx;
    logic [5:0]  bit_cnt_r, cnt_nx;
    logic        word_ws_r, word_ws_nx;
    logic        start_s, take_s, cap_nx, frame_err_nx, shift_nx, data_in_nx;
    logic        shift_r, data_in_r, frame_err_r;
    logic        cap_pend_r, cap_pend_ws_r, cap_r, cap_ws_r;
    logic [31:0] hold_left_r, hold_right_r;
    logic        left_have_r, pair_done_r;
    logic [31:0] left_out_r, right_out_r;
    logic        sample_valid_r, overrun_r;

    // Input synchronizer chains for the asynchronous I2S pins.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            ws_sync_r  <= {SYNC_STAGES{1'b0}};
            sd_sync_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], i2s_sck};
            ws_sync_r  <= {ws_sync_r[SYNC_STAGES-2:0], i2s_ws};
            sd_sync_r  <= {sd_sync_r[SYNC_STAGES-2:0], i2s_sd};
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign ws_s       = ws_sync_r[SYNC_STAGES-1];
    assign sd_s       = sd_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    // The first rise after reset only seeds the WS history, so a fresh WS edge is required.
    assign ws_chg_s   = sck_rise_s & ws_valid_r & (ws_s != ws_smp_r);

    // SCK edge history and WS sampled on each SCK rise.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            sck_prev_r <= 1'b0;
            ws_smp_r   <= 1'b0;
            ws_valid_r <= 1'b0;
        end else begin
            sck_prev_r <= sck_s;
            if (sck_rise_s) begin
                ws_smp_r   <= ws_s;
                ws_valid_r <= 1'b1;
            end
        end
    end

    // Framing FSM next state; the WS-change rise carries the previous word's last bit in I2S.
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = bit_cnt_r;
        word_ws_nx   = word_ws_r;
        frame_err_nx = 1'b0;
        start_s      = 1'b0;
        take_s       = 1'b0;
        cap_nx       = 1'b0;
        case (state_r)
            ST_IDLE:  start_s = ws_chg_s;
            ST_WAIT:  start_s = ws_chg_s;
            ST_DELAY: begin
                start_s = ws_chg_s;
                take_s  = sck_rise_s & ~ws_chg_s;
            end
            ST_SHIFT: begin
                start_s      = ws_chg_s;
                frame_err_nx = ws_chg_s;
                take_s       = sck_rise_s & ~ws_chg_s;
            end
            default:  state_nx = ST_IDLE;
        endcase
        if (start_s) begin
            word_ws_nx = ws_s;
            cnt_nx     = 6'd0;
`ifdef I2S_RCVR_LEFT_JUSTIFIED_EN
            take_s     = 1'b1;
`else
            state_nx   = ST_DELAY;
`endif
        end else begin
            word_ws_nx = word_ws_r;
        end
        if (take_s) begin
            if (cnt_nx == WORD_LAST) begin
                state_nx = ST_WAIT;
                cap_nx   = 1'b1;
            end else begin
                state_nx = ST_SHIFT;
                cap_nx   = 1'b0;
            end
            cnt_nx = cnt_nx + 6'd1;
        end else begin
            cap_nx = 1'b0;
        end
        shift_nx   = take_s;
        data_in_nx = take_s & sd_s;
    end

    // FSM state and registered shift-register drive.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 6'd0;
            word_ws_r   <= 1'b0;
            shift_r     <= 1'b0;
            data_in_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            bit_cnt_r   <= cnt_nx;
            word_ws_r   <= word_ws_nx;
            shift_r     <= shift_nx;
            data_in_r   <= data_in_nx;
            frame_err_r <= frame_err_nx;
        end
    end

    // Capture strobe delayed two cycles so the shift register already holds the final bit.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            cap_pend_r    <= 1'b0;
            cap_pend_ws_r <= 1'b0;
            cap_r         <= 1'b0;
            cap_ws_r      <= 1'b0;
        end else begin
            cap_pend_r    <= cap_nx;
            cap_pend_ws_r <= word_ws_nx;
            cap_r         <= cap_pend_r;
            cap_ws_r      <= cap_pend_ws_r;
        end
    end

    // Per-channel holding registers and left/right pairing.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            hold_left_r  <= 32'h0;
            hold_right_r <= 32'h0;
            left_have_r  <= 1'b0;
            pair_done_r  <= 1'b0;
        end else begin
            pair_done_r <= 1'b0;
            if (cap_r && !cap_ws_r) hold_left_r  <= sr_data & WORD_MASK;
            if (cap_r &&  cap_ws_r) hold_right_r <= sr_data & WORD_MASK;
            if (frame_err_nx) begin
                left_have_r <= 1'b0;
            end else if (cap_r && !cap_ws_r) begin
                left_have_r <= 1'b1;
            end else if (cap_r && cap_ws_r && left_have_r) begin
                left_have_r <= 1'b0;
                pair_done_r <= 1'b1;
            end
        end
    end

    // Output pair handshake and sticky overrun (a new overrun beats clear).
    always_ff @(posedge clk) begin
        if (n_rst) begin
            left_out_r     <= 32'h0;
            right_out_r    <= 32'h0;
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (pair_done_r && (!sample_valid_r || sample_ready)) begin
                left_out_r     <= hold_left_r;
                right_out_r    <= hold_right_r;
                sample_valid_r <= 1'b1;
            end else if (sample_valid_r && sample_ready) begin
                sample_valid_r <= 1'b0;
            end
            if (pair_done_r && sample_valid_r && !sample_ready) begin
                overrun_r <= 1'b1;
            end else if (clear_overrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign shift        = shift_r;
    assign data_in      = data_in_r;
    assign frame_err    = frame_err_r;
    assign left_out     = left_out_r;
    assign right_out    = right_out_r;
    assign sample_valid = sample_valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_i2s_rcvr_ctrl.sv
// Directed, table-driven bench for i2s_rcvr_ctrl; includes a behavioural shift register
// and an I2S (or left-justified) transmitter with SCK = clk/8 and 32 SCK per channel.
module tb_i2s_rcvr_ctrl;

    logic        clk = 1'b0;
    logic        n_rst, i2s_sck, i2s_ws, i2s_sd;
    logic        shift, data_in;
    logic [31:0] sr_data;
    logic [31:0] left_out, right_out;
    logic        sample_valid, sample_ready, overrun, clear_overrun, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int shift_tot = 0;
    int ferr_tot  = 0;
    int valid_tot = 0;

`ifdef I2S_RCVR_LEFT_JUSTIFIED_EN
    localparam int MSB_SLOT = 0;
`else
    localparam int MSB_SLOT = 1;
`endif

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [31:0] exp_left;
        logic [31:0] exp_right;
    } vec_t;

    vec_t vecs [4];

    i2s_rcvr_ctrl #(.WORD_BITS(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .n_rst(n_rst), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .shift(shift), .data_in(data_in), .sr_data(sr_data),
        .left_out(left_out), .right_out(right_out),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .clear_overrun(clear_overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Downstream shift register fed by the DUT.
    always @(posedge clk) begin
        if (n_rst)      sr_data <= 32'h0;
        else if (shift) sr_data <= {sr_data[30:0], data_in};
    end

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (shift)        shift_tot <= shift_tot + 1;
        if (frame_err)    ferr_tot  <= ferr_tot + 1;
        if (sample_valid) valid_tot <= valid_tot + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic ws, input logic sd);
        i2s_sck = 1'b0;
        i2s_ws  = ws;
        i2s_sd  = sd;
        repeat (4) @(posedge clk);
        #1;
        i2s_sck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_slots(input logic ws, input logic [23:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int idx;
            logic b;
            idx = i - MSB_SLOT;
            b = 1'b0;
            if (idx >= 0 && idx < 24) b = word[23 - idx];
            send_bit(ws, b);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slots(1'b0, l, 0, 31);
        send_slots(1'b1, r, 0, 31);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1;
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
    endtask

    initial begin
        int s0, s1, f0, v0;
        vecs[0] = '{24'hA5A5A5, 24'h3C3C3C, 32'h00A5A5A5, 32'h003C3C3C};
        vecs[1] = '{24'hFFFFFF, 24'hABCDEF, 32'h00FFFFFF, 32'h00ABCDEF};
        vecs[2] = '{24'h800001, 24'h7FFFFE, 32'h00800001, 32'h007FFFFE};
        vecs[3] = '{24'h123456, 24'h000000, 32'h00123456, 32'h00000000};

        n_rst = 1'b1; i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
        sample_ready = 1'b0; clear_overrun = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_shift", {31'h0, shift}, 32'h0);
        check("rst_data_in", {31'h0, data_in}, 32'h0);
        check("rst_left", left_out, 32'h0);
        check("rst_right", right_out, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        @(posedge clk); #1;
        n_rst = 1'b0;

        // preamble: seeds WS history; the right word has no left partner
        send_slots(1'b1, 24'h0, 0, 31);
        check("preamble_no_valid", {31'h0, sample_valid}, 32'h0);

        // table of full frames, consumer idle until after the check
        for (int v = 0; v < 4; v++) begin
            s0 = shift_tot; f0 = ferr_tot;
            send_slots(1'b0, vecs[v].left, 0, 31);
            s1 = shift_tot;
            send_slots(1'b1, vecs[v].right, 0, 31);
            @(negedge clk);
            check("vec_shifts_left", 32'(s1 - s0), 32'd24);
            check("vec_shifts_right", 32'(shift_tot - s1), 32'd24);
            check("vec_frame_err", 32'(ferr_tot - f0), 32'd0);
            check("vec_valid", {31'h0, sample_valid}, 32'h1);
            check("vec_left", left_out, vecs[v].exp_left);
            check("vec_right", right_out, vecs[v].exp_right);
            pulse_ready();
            @(negedge clk);
            check("vec_consumed", {31'h0, sample_valid}, 32'h0);
        end

        // ready held high: one valid cycle per frame, no overrun
        sample_ready = 1'b1;
        v0 = valid_tot;
        for (int v = 0; v < 4; v++) send_frame(vecs[v].left, vecs[v].right);
        @(negedge clk);
        check("stream_valid_cycles", 32'(valid_tot - v0), 32'd4);
        check("stream_overrun", {31'h0, overrun}, 32'h0);
        check("stream_left", left_out, 32'h00123456);
        sample_ready = 1'b0;

        // consumer stalled for two frames: first pair held, overrun set
        send_frame(24'hA5A5A5, 24'h3C3C3C);
        send_frame(24'h111111, 24'h222222);
        @(negedge clk);
        check("ovr_valid", {31'h0, sample_valid}, 32'h1);
        check("ovr_left_held", left_out, 32'h00A5A5A5);
        check("ovr_right_held", right_out, 32'h003C3C3C);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        @(posedge clk); #1;
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared", {31'h0, overrun}, 32'h0);
        check("ovr_valid_kept", {31'h0, sample_valid}, 32'h1);
        pulse_ready();
        @(negedge clk);
        check("ovr_consumed", {31'h0, sample_valid}, 32'h0);

        // short left word (10 data bits): one frame_err, pair dropped
        f0 = ferr_tot;
        send_slots(1'b0, 24'h5A5A5A, 0, 10);
        send_slots(1'b1, 24'h333333, 0, 31);
        @(negedge clk);
        check("short_frame_err", 32'(ferr_tot - f0), 32'd1);
        check("short_no_valid", {31'h0, sample_valid}, 32'h0);
        send_frame(24'hC0FFEE, 24'h0BEEF0);
        @(negedge clk);
        check("short_next_valid", {31'h0, sample_valid}, 32'h1);
        check("short_next_left", left_out, 32'h00C0FFEE);
        check("short_next_right", right_out, 32'h000BEEF0);

        // reset in the middle of a left word with a pair still pending
        send_slots(1'b0, 24'h5A5A5A, 0, 10);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_shift", {31'h0, shift}, 32'h0);
        check("mid_rst_data_in", {31'h0, data_in}, 32'h0);
        check("mid_rst_left", left_out, 32'h0);
        check("mid_rst_right", right_out, 32'h0);
        check("mid_rst_valid", {31'h0, sample_valid}, 32'h0);
        check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        check("mid_rst_frame_err", {31'h0, frame_err}, 32'h0);
        s0 = shift_tot;
        send_slots(1'b0, 24'h5A5A5A, 11, 31);
        @(negedge clk);
        check("mid_rst_no_shift", 32'(shift_tot - s0), 32'd0);
        send_slots(1'b1, 24'h444444, 0, 31);
        check("mid_rst_orphan_right", {31'h0, sample_valid}, 32'h0);
        send_frame(24'h800001, 24'h00FF00);
        @(negedge clk);
        check("post_rst_valid", {31'h0, sample_valid}, 32'h1);
        check("post_rst_left", left_out, 32'h00800001);
        check("post_rst_right", right_out, 32'h0000FF00);
        check("post_rst_overrun", {31'h0, overrun}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
